// File: rtl/sync_pkg.sv
// Shared limits and sizing helper for the filtered synchronizer family.
// Latency: n/a (elaboration-time constants only).
// Backpressure: n/a.
package sync_pkg;

  localparam int DEPTH_MIN  = 2;
  localparam int DEPTH_MAX  = 8;
  localparam int FILTER_MAX = 65535;

  // Stability counter width: clog2(FILTER+1), never narrower than one bit.
  function automatic int cnt_width(input int filter);
    int w;
    w = $clog2(filter + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_shift_reg_filtered_if.sv
// Bundle of the synchronizer's data-side signals: raw input, filtered value, edge pulses.
// Latency: n/a (wires only).
// Backpressure: none; the input is sampled every cycle and outputs are free-running.
interface sync_shift_reg_filtered_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] d;     // asynchronous / foreign-domain input bits
  logic [WIDTH-1:0] q;     // synchronized, filtered value
  logic [WIDTH-1:0] rise;  // one-cycle pulse on q 0->1
  logic [WIDTH-1:0] fall;  // one-cycle pulse on q 1->0

  // Source side drives d and observes the results.
  modport master (
    output d,
    input  q,
    input  rise,
    input  fall
  );

  // Synchronizer side consumes d and produces the results.
  modport slave (
    input  d,
    output q,
    output rise,
    output fall
  );

endinterface

// File: rtl/sync_filter_bit.sv
// One synchronized bit: DEPTH-stage chain, optional stability filter, q register, edge pulses.
// Latency: DEPTH+1 cycles with FILTER=0, DEPTH+FILTER cycles for a clean step otherwise.
// Backpressure: none; d_i is sampled every cycle.
module sync_filter_bit
  import sync_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter bit INIT_BIT = 1'b0,
  parameter int FILTER   = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // Stage 0 is the LSB; the MSB is the fully resolved sync output.
  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;
  logic             sync_bit;

  logic q_q;
  logic q_d;
  logic rise_q;
  logic rise_d;
  logic fall_q;
  logic fall_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d_i};
  end

  assign sync_bit = sync_q[DEPTH-1];

  // Synchronizer chain; every stage reloads INIT on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {DEPTH{INIT_BIT}};
    end else begin
      sync_q <= sync_d;
    end
  end

  if (FILTER == 0) begin : g_no_filter

    // Without a filter q simply registers the resolved sync bit.
    always_comb begin
      q_d = sync_bit;
    end

  end else begin : g_filter

    localparam int             CW       = cnt_width(FILTER);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive cycles where sync disagrees with q; accept after FILTER of them.
    // Any cycle where they agree throws the partial count away.
    always_comb begin
      cnt_d = cnt_q;
      q_d   = q_q;
      if (sync_bit == q_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        q_d   = sync_bit;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Stability counter register; it tops out at FILTER-1 so it can never wrap.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

  end

  // Pulses are computed from the q transition that is about to be registered,
  // so each pulse lines up with the first cycle q shows its new value.
  always_comb begin
    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
  end

  // Output value and edge pulses; reset forces q to INIT without any pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q    <= INIT_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q_o    = q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sync_shift_reg_filtered.sv
// Multi-bit synchronizer with per-bit glitch filter and registered rise/fall pulses.
// Latency: DEPTH+1 cycles (FILTER=0) or DEPTH+FILTER cycles (FILTER>0); bits resolve independently.
// Backpressure: none; io.d is sampled every cycle, no combinational path to any output.
module sync_shift_reg_filtered
  import sync_pkg::*;
#(
  parameter int          WIDTH  = 1,
  parameter int          DEPTH  = 3,
  parameter logic [63:0] INIT   = 64'd0,
  parameter int          FILTER = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  sync_shift_reg_filtered_if.slave  io
);

  // INIT is carried in a 64-bit container; anything set above bit WIDTH-1 is a user error.
  localparam bit INIT_TOO_WIDE = (WIDTH < 64) ? ((INIT >> WIDTH) != 64'd0) : 1'b0;

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $fatal(1, "sync_shift_reg_filtered: DEPTH=%0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
  end

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "sync_shift_reg_filtered: WIDTH=%0d outside 1..64", WIDTH);
  end

  if (INIT_TOO_WIDE) begin : g_bad_init
    $fatal(1, "sync_shift_reg_filtered: INIT has bits set above WIDTH=%0d", WIDTH);
  end

  if (FILTER < 0 || FILTER > FILTER_MAX) begin : g_bad_filter
    $fatal(1, "sync_shift_reg_filtered: FILTER=%0d outside 0..%0d", FILTER, FILTER_MAX);
  end

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  // Bits share nothing but clock and reset; multi-bit words are not kept coherent.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sync_filter_bit #(
      .DEPTH    (DEPTH),
      .INIT_BIT (INIT[i]),
      .FILTER   (FILTER)
    ) u_bit (
      .clock  (clock),
      .reset  (reset),
      .d_i    (io.d[i]),
      .q_o    (q_w[i]),
      .rise_o (rise_w[i]),
      .fall_o (fall_w[i])
    );
  end

  assign io.q    = q_w;
  assign io.rise = rise_w;
  assign io.fall = fall_w;

endmodule

// File: tb/tb_sync_shift_reg_filtered.sv
module tb_sync_shift_reg_filtered;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  // A: 4 bits, DEPTH=3, INIT=1010, no filter.  B: 1 bit, DEPTH=2, INIT=0, FILTER=4.
  sync_shift_reg_filtered_if #(.WIDTH(4)) if_a ();
  sync_shift_reg_filtered_if #(.WIDTH(1)) if_b ();

  sync_shift_reg_filtered #(
    .WIDTH(4), .DEPTH(3), .INIT(64'hA), .FILTER(0)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .io    (if_a)
  );

  sync_shift_reg_filtered #(
    .WIDTH(1), .DEPTH(2), .INIT(64'h0), .FILTER(4)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .io    (if_b)
  );

  typedef struct {
    int         cyc;
    bit         is_b;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic exp_a(input int c, input logic [3:0] q, input logic [3:0] r,
                       input logic [3:0] f, input string nm);
    exp_t e;
    e.cyc = c; e.is_b = 1'b0; e.q = q; e.rise = r; e.fall = f; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_b(input int c, input logic q, input logic r, input logic f,
                       input string nm);
    exp_t e;
    e.cyc = c; e.is_b = 1'b1; e.q = {3'b000, q}; e.rise = {3'b000, r};
    e.fall = {3'b000, f}; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: every cycle, pop and compare all expectations due now.
  initial begin
    forever begin
      @(negedge clock);
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].cyc <= cyc) begin
          logic [3:0] aq;
          logic [3:0] ar;
          logic [3:0] af;
          if (sb[k].is_b) begin
            aq = {3'b000, if_b.q};
            ar = {3'b000, if_b.rise};
            af = {3'b000, if_b.fall};
          end else begin
            aq = if_a.q;
            ar = if_a.rise;
            af = if_a.fall;
          end
          tests++;
          if (sb[k].cyc != cyc || aq !== sb[k].q || ar !== sb[k].rise || af !== sb[k].fall) begin
            fails++;
            $display("FAIL %s @cyc %0d (due %0d): q/rise/fall got %b/%b/%b want %b/%b/%b",
                     sb[k].name, cyc, sb[k].cyc, aq, ar, af, sb[k].q, sb[k].rise, sb[k].fall);
          end
          sb.delete(k);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    if_a.d = 4'b0000;
    if_b.d = 1'b0;
    reset  = 1'b1;
    step(2);
    reset = 1'b0;
    t = cyc;

    // Reset value and flush of INIT through the DEPTH=3 chain.
    for (int c = 0; c < 4; c++) exp_a(t + c, 4'b1010, 4'b0000, 4'b0000, "reset_val_a");
    exp_a(t + 4, 4'b0000, 4'b0000, 4'b1010, "init_flush_fall");
    exp_a(t + 5, 4'b0000, 4'b0000, 4'b0000, "init_flush_after");
    exp_b(t,     1'b0, 1'b0, 1'b0, "reset_val_b");
    exp_b(t + 1, 1'b0, 1'b0, 1'b0, "reset_val_b1");

    // Glitch of 3 cycles on B never reaches q.
    goto(t + 2);
    if_b.d = 1'b1;
    for (int c = 2; c <= 14; c++) exp_b(t + c, 1'b0, 1'b0, 1'b0, "glitch_reject");
    goto(t + 5);
    if_b.d = 1'b0;

    // No-filter latency: io_d edge at t+6 shows at t+10.
    goto(t + 6);
    if_a.d = 4'b0001;
    for (int c = 6; c <= 9; c++) exp_a(t + c, 4'b0000, 4'b0000, 4'b0000, "lat_before");
    exp_a(t + 10, 4'b0001, 4'b0001, 4'b0000, "lat_rise");
    exp_a(t + 11, 4'b0001, 4'b0000, 4'b0000, "lat_after");

    // Two bits rising together.
    goto(t + 12);
    if_a.d = 4'b0111;
    for (int c = 12; c <= 15; c++) exp_a(t + c, 4'b0001, 4'b0000, 4'b0000, "multi_before");
    exp_a(t + 16, 4'b0111, 4'b0110, 4'b0000, "multi_rise");
    exp_a(t + 17, 4'b0111, 4'b0000, 4'b0000, "multi_after");

    // Clean 6-cycle pulse on B: q rises DEPTH+FILTER=6 cycles after the edge.
    goto(t + 15);
    if_b.d = 1'b1;
    exp_b(t + 15, 1'b0, 1'b0, 1'b0, "filt_wait0");
    exp_b(t + 20, 1'b0, 1'b0, 1'b0, "filt_wait5");
    exp_b(t + 21, 1'b1, 1'b1, 1'b0, "filt_rise");
    exp_b(t + 22, 1'b1, 1'b0, 1'b0, "filt_rise_after");

    // One bit falling only.
    goto(t + 18);
    if_a.d = 4'b0101;
    for (int c = 18; c <= 21; c++) exp_a(t + c, 4'b0111, 4'b0000, 4'b0000, "fall_before");
    exp_a(t + 22, 4'b0101, 4'b0000, 4'b0010, "single_fall");
    exp_a(t + 23, 4'b0101, 4'b0000, 4'b0000, "fall_after");

    goto(t + 21);
    if_b.d = 1'b0;
    for (int c = 23; c <= 26; c++) exp_b(t + c, 1'b1, 1'b0, 1'b0, "filt_hold_high");
    exp_b(t + 27, 1'b0, 1'b0, 1'b1, "filt_fall");
    exp_b(t + 28, 1'b0, 1'b0, 1'b0, "filt_fall_after");

    // Counter restart: 1,1,1,0 then steady 1 -> rise only after the final four.
    goto(t + 30);
    if_b.d = 1'b1;
    for (int c = 30; c <= 39; c++) exp_b(t + c, 1'b0, 1'b0, 1'b0, "restart_hold");
    exp_b(t + 40, 1'b1, 1'b1, 1'b0, "restart_rise");
    goto(t + 33);
    if_b.d = 1'b0;
    goto(t + 34);
    if_b.d = 1'b1;

    // Reset mid-operation: no pulses from the forced change, full latency afterwards.
    goto(t + 41);
    reset = 1'b1;
    exp_a(t + 41, 4'b0101, 4'b0000, 4'b0000, "pre_reset_a");
    exp_b(t + 41, 1'b1, 1'b0, 1'b0, "pre_reset_b");
    goto(t + 42);
    reset = 1'b0;
    for (int c = 42; c <= 45; c++) exp_a(t + c, 4'b1010, 4'b0000, 4'b0000, "midrst_a");
    exp_a(t + 46, 4'b0101, 4'b0101, 4'b1010, "midrst_resync_a");
    exp_a(t + 47, 4'b0101, 4'b0000, 4'b0000, "midrst_after_a");
    for (int c = 42; c <= 47; c++) exp_b(t + c, 1'b0, 1'b0, 1'b0, "midrst_b");
    exp_b(t + 48, 1'b1, 1'b1, 1'b0, "midrst_resync_b");
    exp_b(t + 49, 1'b1, 1'b0, 1'b0, "midrst_after_b");

    goto(t + 52);
    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
